// File: rtl/fadd_issue_q.sv
// fadd_issue_q: credit-limited issue/collect shell around a fixed-latency pipelined adder
module fadd_issue_q #(
    parameter int LAT   = 3,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] fa_x1,
    output logic [31:0] fa_x2,
    input  logic [31:0] fa_y,
    input  logic        fa_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_ovf,
    output logic        ovf_sticky,
    input  logic        ovf_clr,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    logic [LAT:0]  vld_q, vld_d;
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   x1_q, x2_q;
    logic          sticky_q;
    logic [32:0]   mem_q [DEPTH];
    logic [32:0]   head;
    logic          acc, wr, rd;

    // Credits count every pair already accepted but not yet popped, so the FIFO can never overflow;
    // rstn gates it so nothing is offered while reset is held.
    assign in_ready   = rstn && (int'(cnt_q) + $countones(vld_q) < DEPTH);
    assign out_valid  = cnt_q != '0;
    assign head       = mem_q[rp_q];
    assign out_y      = out_valid ? head[32:1] : '0;
    assign out_ovf    = out_valid ? head[0] : 1'b0;
    assign fa_x1      = x1_q;
    assign fa_x2      = x2_q;
    assign ovf_sticky = sticky_q;
    assign busy       = |vld_q || out_valid;

    // Handshake decode and next-state for the in-flight tracker and occupancy
    always_comb begin
        acc   = in_valid && in_ready;
        wr    = vld_q[LAT];
        rd    = out_valid && out_ready;
        vld_d = {vld_q[LAT-1:0], acc};
        cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    // Operand registers, in-flight shift register, FIFO pointers and sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x1_q     <= '0;
            x2_q     <= '0;
            vld_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (acc) begin
                x1_q <= in_a;
                x2_q <= in_b;
            end
            vld_q    <= vld_d;
            wp_q     <= wr ? wp_q + AW'(1) : wp_q;
            rp_q     <= rd ? rp_q + AW'(1) : rp_q;
            cnt_q    <= cnt_d;
            sticky_q <= (wr && fa_ovf) ? 1'b1 : (ovf_clr ? 1'b0 : sticky_q);
        end
    end

    // Result storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= {fa_y, fa_ovf};
    end
endmodule
